// File: rtl/epl_read_buffer_sub_pkg.sv
// Common types and widths for the read buffer: array geometry taken from the
// EPLFFRAM02 header plus the per-cycle FIFO control bundle.
`include "EPLFFRAM02_spec.vh"

package epl_read_buffer_sub_pkg;

    localparam int unsigned COLUMN_W = `COLUMN;
    localparam int unsigned SEL_W    = `ADDR_AYO;
    localparam int unsigned WORD_W   = `WORD;

    typedef struct packed {
        logic push;
        logic pop;
        logic ovf;
    } rb_ctl_t;

    // Picks column word 'sel' out of a full array row.
    function automatic logic [WORD_W-1:0] col_word(input logic [COLUMN_W-1:0] row,
                                                   input logic [SEL_W-1:0]    sel);
        return row[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/EPLFFRAM02_spec.vh
// Shared geometry of the EPLFFRAM02 array: row width, column-select width and
// the per-column word width derived from them.
`ifndef EPLFFRAM02_SPEC_VH
`define EPLFFRAM02_SPEC_VH
`define COLUMN 32
`define ADDR_AYO 2
`define WORD (`COLUMN >> `ADDR_AYO)
`endif

// File: rtl/epl_read_buffer_sub_word_fifo.sv
// Word FIFO: storage, wrapping pointers and occupancy count. The caller only
// pushes when there is room (or a pop frees it) and only pops when non-empty.
module epl_Word_Fifo_sub #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; an empty FIFO masks it to zero below.
    always_ff @(posedge clk) begin
        if (push && !rst) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/epl_read_buffer_sub.sv
// Read buffer between the EPLFFRAM02 array and its consumer: selects one column
// word per read, queues it, and raises stall/overflow for the issuing side.
`include "EPLFFRAM02_spec.vh"

module epl_read_buffer_sub
    import epl_read_buffer_sub_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                      pClk_i,
    input  logic                      pRst_i,
    input  logic [`COLUMN-1:0]        pDto_i,
    input  logic                      pRead01_i,
    input  logic [`ADDR_AYO-1:0]      pAcy2_i,
    output logic [WORD_W-1:0]         pDo_o,
    output logic                      pDoVld_o,
    input  logic                      pDoRdy_i,
    output logic                      pStall_o,
    output logic [$clog2(DEPTH):0]    pLvl_o,
    output logic                      pOvf_o,
    input  logic                      pOvfClr_i
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]  count;
    logic [WORD_W-1:0] sel_word;
    rb_ctl_t           ctl;
    logic              ovf_q, ovf_d;

    assign sel_word = col_word(pDto_i, pAcy2_i);

    // A full FIFO still accepts a read if the head leaves in the same cycle.
    always_comb begin
        ctl      = '0;
        ctl.pop  = (count != '0) && pDoRdy_i;
        ctl.push = pRead01_i && ((count < CNT_W'(DEPTH)) || ctl.pop);
        ctl.ovf  = pRead01_i && !ctl.push;
        ovf_d    = ovf_q;
        if (pOvfClr_i) ovf_d = 1'b0;
        if (ctl.ovf)   ovf_d = 1'b1;
    end

    always_ff @(posedge pClk_i or posedge pRst_i) begin
        if (pRst_i) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    epl_Word_Fifo_sub #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk   (pClk_i),
        .rst   (pRst_i),
        .push  (ctl.push),
        .pop   (ctl.pop),
        .wdata (sel_word),
        .rdata (pDo_o),
        .count (count)
    );

    // Stall one entry early: a read already requested from the array still lands.
    assign pStall_o = (count >= CNT_W'(DEPTH - 1));
    assign pDoVld_o = (count != '0);
    assign pLvl_o   = count;
    assign pOvf_o   = ovf_q;

endmodule

// File: tb/tb_epl_read_buffer_sub.sv
// Self-checking bench for epl_read_buffer_sub: directed scenarios plus random
// traffic checked against a queue-based model of the buffer.
module tb_epl_read_buffer_sub;

    localparam int DEPTH = 4;

    logic        pClk_i = 1'b0;
    logic        pRst_i = 1'b1;
    logic [31:0] pDto_i = '0;
    logic        pRead01_i = 1'b0;
    logic [1:0]  pAcy2_i = '0;
    logic [7:0]  pDo_o;
    logic        pDoVld_o;
    logic        pDoRdy_i = 1'b0;
    logic        pStall_o;
    logic [2:0]  pLvl_o;
    logic        pOvf_o;
    logic        pOvfClr_i = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] mq[$];
    bit         movf = 1'b0;

    epl_read_buffer_sub #(.DEPTH(DEPTH)) dut (
        .pClk_i    (pClk_i),
        .pRst_i    (pRst_i),
        .pDto_i    (pDto_i),
        .pRead01_i (pRead01_i),
        .pAcy2_i   (pAcy2_i),
        .pDo_o     (pDo_o),
        .pDoVld_o  (pDoVld_o),
        .pDoRdy_i  (pDoRdy_i),
        .pStall_o  (pStall_o),
        .pLvl_o    (pLvl_o),
        .pOvf_o    (pOvf_o),
        .pOvfClr_i (pOvfClr_i)
    );

    always #5 pClk_i = ~pClk_i;

    // Applies one cycle of inputs, advances the model by the buffer's rules,
    // then returns 1 time unit after the rising edge with inputs idled.
    task automatic drive(input bit rd, input logic [31:0] dto, input logic [1:0] sel,
                         input bit rdy, input bit clr);
        bit         pop;
        bit         ovf_set;
        logic [7:0] w;
        pRead01_i = rd;
        pDto_i    = dto;
        pAcy2_i   = sel;
        pDoRdy_i  = rdy;
        pOvfClr_i = clr;
        w       = dto[sel*8 +: 8];
        pop     = (mq.size() != 0) && rdy;
        ovf_set = rd && (mq.size() == DEPTH) && !pop;
        if (pop) void'(mq.pop_front());
        if (rd && !ovf_set) mq.push_back(w);
        if (ovf_set) movf = 1'b1;
        else if (clr) movf = 1'b0;
        @(posedge pClk_i);
        #1;
        pRead01_i = 1'b0;
        pDoRdy_i  = 1'b0;
        pOvfClr_i = 1'b0;
        pDto_i    = $urandom;
        pAcy2_i   = 2'($urandom);
    endtask

    task automatic test_reset();
        #1;
        tests_run += 5;
        if (pLvl_o !== 3'd0)   begin tests_failed++; $display("[TB] FAIL reset_lvl got %0d want 0", pLvl_o); end
        if (pDoVld_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_vld got %b want 0", pDoVld_o); end
        if (pDo_o !== 8'h00)   begin tests_failed++; $display("[TB] FAIL reset_do got %h want 00", pDo_o); end
        if (pStall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_stall got %b want 0", pStall_o); end
        if (pOvf_o !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_ovf got %b want 0", pOvf_o); end
        @(negedge pClk_i);
        pRst_i = 1'b0;
        @(posedge pClk_i);
        #1;
    endtask

    task automatic test_single_read();
        drive(1, 32'hDDCCBBAA, 2'd2, 1, 0);
        tests_run += 2;
        if (pDo_o !== 8'hCC)   begin tests_failed++; $display("[TB] FAIL single_do got %h want cc", pDo_o); end
        if (pDoVld_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_vld got %b want 1", pDoVld_o); end
        drive(0, 32'h0, 2'd0, 1, 0);
        tests_run++;
        if (pDoVld_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_vld_after got %b want 0", pDoVld_o); end
    endtask

    task automatic test_fill_drain();
        logic [7:0] exp_words [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            drive(1, 32'h44332211, 2'(i), 0, 0);
            tests_run += 2;
            if (pLvl_o !== 3'(i + 1)) begin tests_failed++; $display("[TB] FAIL fill_lvl%0d got %0d want %0d", i, pLvl_o, i + 1); end
            if (pStall_o !== (i >= 2)) begin tests_failed++; $display("[TB] FAIL fill_stall%0d got %b want %b", i, pStall_o, i >= 2); end
        end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (pDo_o !== exp_words[i]) begin tests_failed++; $display("[TB] FAIL drain_do%0d got %h want %h", i, pDo_o, exp_words[i]); end
            drive(0, 32'h0, 2'd0, 1, 0);
        end
        tests_run++;
        if (pLvl_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL drain_lvl got %0d want 0", pLvl_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) drive(1, 32'hA0A1A2A3, 2'(i), 0, 0);
        drive(1, 32'h5A5A5A5A, 2'd1, 0, 0);
        tests_run += 3;
        if (pLvl_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL ovf_lvl got %0d want 4", pLvl_o); end
        if (pOvf_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set got %b want 1", pOvf_o); end
        if (pDo_o !== 8'hA3) begin tests_failed++; $display("[TB] FAIL ovf_head got %h want a3", pDo_o); end
        drive(0, 32'h0, 2'd0, 0, 1);
        tests_run++;
        if (pOvf_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_clr got %b want 0", pOvf_o); end
        drive(1, 32'h12345678, 2'd0, 0, 1);
        tests_run++;
        if (pOvf_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set_wins got %b want 1", pOvf_o); end
        drive(0, 32'h0, 2'd0, 0, 1);
    endtask

    task automatic test_full_push_pop();
        drive(1, 32'h000000EE, 2'd0, 1, 0);
        tests_run += 3;
        if (pLvl_o !== 3'd4) begin tests_failed++; $display("[TB] FAIL fpp_lvl got %0d want 4", pLvl_o); end
        if (pOvf_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL fpp_ovf got %b want 0", pOvf_o); end
        if (pDo_o !== 8'hA2) begin tests_failed++; $display("[TB] FAIL fpp_head got %h want a2", pDo_o); end
        for (int i = 0; i < 3; i++) drive(0, 32'h0, 2'd0, 1, 0);
        tests_run++;
        if (pDo_o !== 8'hEE) begin tests_failed++; $display("[TB] FAIL fpp_tail got %h want ee", pDo_o); end
        drive(0, 32'h0, 2'd0, 1, 0);
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) drive(1, 32'h0F0E0D0C, 2'(i), 0, 0);
        drive(1, 32'h0, 2'd0, 0, 0);
        drive(0, 32'h0, 2'd0, 1, 0);
        tests_run += 2;
        if (pLvl_o !== 3'd3) begin tests_failed++; $display("[TB] FAIL pre_rst_lvl got %0d want 3", pLvl_o); end
        if (pOvf_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL pre_rst_ovf got %b want 1", pOvf_o); end
        #2;
        pRst_i = 1'b1;
        #1;
        tests_run += 5;
        if (pLvl_o !== 3'd0)   begin tests_failed++; $display("[TB] FAIL arst_lvl got %0d want 0", pLvl_o); end
        if (pDoVld_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_vld got %b want 0", pDoVld_o); end
        if (pDo_o !== 8'h00)   begin tests_failed++; $display("[TB] FAIL arst_do got %h want 00", pDo_o); end
        if (pStall_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL arst_stall got %b want 0", pStall_o); end
        if (pOvf_o !== 1'b0)   begin tests_failed++; $display("[TB] FAIL arst_ovf got %b want 0", pOvf_o); end
        mq.delete();
        movf = 1'b0;
        pRead01_i = 1'b1;
        pDto_i    = 32'hFFFFFFFF;
        @(posedge pClk_i);
        #1;
        pRead01_i = 1'b0;
        pRst_i    = 1'b0;
        tests_run++;
        if (pLvl_o !== 3'd0) begin tests_failed++; $display("[TB] FAIL rst_edge_push got %0d want 0", pLvl_o); end
        test_single_read();
    endtask

    task automatic test_wrap();
        for (int i = 1; i <= 10; i++) begin
            drive(1, {24'h0, 8'(i)}, 2'd0, 1, 0);
            tests_run += 2;
            if (pDo_o !== 8'(i)) begin tests_failed++; $display("[TB] FAIL wrap_do%0d got %h want %h", i, pDo_o, 8'(i)); end
            if (pLvl_o > 3'd1)   begin tests_failed++; $display("[TB] FAIL wrap_lvl%0d got %0d want <=1", i, pLvl_o); end
        end
        drive(0, 32'h0, 2'd0, 1, 0);
    endtask

    task automatic test_random();
        logic [7:0] exp_do;
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 99) < 60), $urandom, 2'($urandom), ($urandom_range(0, 99) < 45),
                  ($urandom_range(0, 99) < 10));
            exp_do = (mq.size() != 0) ? mq[0] : 8'h00;
            tests_run += 5;
            if (pLvl_o !== 3'(mq.size())) begin tests_failed++; $display("[TB] FAIL rnd_lvl cyc%0d got %0d want %0d", n, pLvl_o, mq.size()); end
            if (pDoVld_o !== (mq.size() != 0)) begin tests_failed++; $display("[TB] FAIL rnd_vld cyc%0d got %b want %b", n, pDoVld_o, mq.size() != 0); end
            if (pDo_o !== exp_do) begin tests_failed++; $display("[TB] FAIL rnd_do cyc%0d got %h want %h", n, pDo_o, exp_do); end
            if (pStall_o !== (mq.size() >= DEPTH - 1)) begin tests_failed++; $display("[TB] FAIL rnd_stall cyc%0d got %b want %b", n, pStall_o, mq.size() >= DEPTH - 1); end
            if (pOvf_o !== movf) begin tests_failed++; $display("[TB] FAIL rnd_ovf cyc%0d got %b want %b", n, pOvf_o, movf); end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fill_drain();
        test_overflow();
        test_full_push_pop();
        test_async_reset();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
